bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
Parametrised up/down BCD counter with parallel load, synchronous clear, and a selectable wrap or saturate mode. It is the successor to the up-only decimal counter used by the display and event-count paths. It adds down-counting, preset, terminal-count flags and overflow/underflow pulses. Digits are packed least-significant first, 4 bits per digit.

Parameters:
DIGITS, 6, number of BCD digits (>=1).
SATURATE, 0, 0 = wrap at the terminal count; 1 = hold at the terminal count.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous reset, active-low.
clear  in  1  synchronous clear to zero.
load  in  1  parallel load strobe.
load_val  in  DIGITS*4  value to load, packed BCD.
up  in  1  count-up enable.
down  in  1  count-down enable.
bcd  out  DIGITS*4  current value (registered).
is_zero  out  1  high when bcd is all zeros (combinational from the register).
is_max  out  1  high when every digit is 9 (combinational from the register).
ovf  out  1  one-cycle pulse: an up-count was attempted at all-9s.
unf  out  1  one-cycle pulse: a down-count was attempted at zero.
load_err  out  1  one-cycle pulse: a load was rejected because load_val held a digit >9.

Behaviour:
- Priority per edge: rst_n low, then clear, then load, then count.
- Reset state: bcd=0, ovf=0, unf=0, load_err=0. As a result is_zero=1 and is_max=0 during reset.
- clear: bcd<=0 and all pulses deassert. load, up and down are ignored in that cycle.
- load with every digit of load_val <=9: bcd<=load_val. up and down are ignored in that cycle.
- load with any digit >9: bcd holds its value, load_err<=1 for one cycle, and up/down are still ignored.
- Effective direction: inc = up & ~down; dec = down & ~up. up and down together means hold, with no pulses.
- Increment:
  - Digit i advances when inc is set and all digits below i are 9.
  - A digit at 9 advances to 0; otherwise it adds 1.
  - The ripple chain is combinational, so the result appears on bcd one cycle after the edge.
- Decrement:
  - Digit i retreats when dec is set and all digits below i are 0.
  - A digit at 0 retreats to 9; otherwise it subtracts 1.
- Terminal count, up direction:
  - inc at all-9s with SATURATE=0: bcd wraps to 0 and ovf<=1.
  - inc at all-9s with SATURATE=1: bcd holds at all-9s and ovf<=1.
- Terminal count, down direction:
  - dec at 0 with SATURATE=0: bcd wraps to all-9s and unf<=1.
  - dec at 0 with SATURATE=1: bcd holds at 0 and unf<=1.
- Pulse timing: ovf, unf and load_err are registered. They are high in the same cycle the new bcd value becomes visible and return low on the next edge unless the condition repeats.
- No-op cycles: with no inc or dec, bcd holds and all pulses are 0.
- Held count inputs: continuous up or down counts every cycle. No edge detection is performed.
- Out-of-range state: the register can only reach an invalid digit through a fault. If it does, that digit is treated as 9 for carry purposes and the next increment of that digit produces 0.
- Reset mid-count: reset wins unconditionally and any pulse in flight is dropped.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - constants BCD_MAX=4'd9 and BCD_ZERO=4'd0.
  - function bcd_valid(bcd_digit_t).
- Sub-module bcd_updown_digit, one instance per digit:
  - Inputs: inc_in, dec_in, clr, ld, ld_val.
  - Outputs: digit, inc_out (=inc_in & digit==9), dec_out (=dec_in & digit==0).
- Top level:
  - chains the digit instances;
  - performs load validation;
  - applies saturate suppression, gating the chain when SATURATE=1 and the terminal condition holds;
  - generates the pulses.

Test Plan:
- DIGITS=3, SATURATE=0: reset, then load 998, then up for 3 cycles. Required: bcd 999, 000, 001; ovf pulses exactly in the cycle bcd=000.
- DIGITS=3, SATURATE=1: load 001, then down for 3 cycles. Required: bcd 000, 000, 000; unf high in the 2nd and 3rd cycles; is_zero=1 throughout.
- DIGITS=3: load 100, then one down. Required: bcd=099 (borrow ripples across two digits); no unf.
- Load 0x1A3. Required: load_err=1 for one cycle and bcd unchanged. Then load 0x123 with up=1 in the same cycle. Required: bcd=123, with the up ignored.
- From 050: up=down=1 for 2 cycles, then clear with load=1. Required: bcd holds 050 with no pulses, then bcd=000.
- Mid-count at 457 with up held: rst_n=0 for one cycle. Required: bcd=000, ovf=0, is_zero=1. After release, counting resumes at 001.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, digit constants and validity helper
//
// Purpose: common definitions for the up/down BCD counter and its digit cells.
// Contents: bcd_digit_t, BCD_MAX, BCD_ZERO, bcd_valid().

package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic logic bcd_valid(bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// rtl/bcd_updown_digit.sv - one BCD digit cell with carry/borrow ripple
//
// Purpose: single decimal digit register that can be cleared, loaded,
//          incremented or decremented, and reports carry/borrow to the next digit.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous reset, active-low
//   inc_in   in   increment request (all lower digits are 9)
//   dec_in   in   decrement request (all lower digits are 0)
//   clr      in   clear digit to zero (highest priority after reset)
//   ld       in   load ld_val
//   ld_val   in   value to load
//   digit    out  registered digit value
//   inc_out  out  carry to next digit: inc_in and this digit at 9
//   dec_out  out  borrow to next digit: dec_in and this digit at 0

module bcd_updown_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_in,
  input  logic       dec_in,
  input  logic       clr,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t digit,
  output logic       inc_out,
  output logic       dec_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;
  logic       at_top;
  logic       at_bottom;

  // A corrupted digit (>9) behaves like 9: it carries and rolls to 0.
  assign at_top    = (digit_q == BCD_MAX) || !bcd_valid(digit_q);
  assign at_bottom = (digit_q == BCD_ZERO);

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_ZERO;
    end else if (ld) begin
      digit_d = ld_val;
    end else if (inc_in) begin
      digit_d = at_top ? BCD_ZERO : digit_q + 4'd1;
    end else if (dec_in) begin
      digit_d = at_bottom ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign inc_out = inc_in & at_top;
  assign dec_out = dec_in & at_bottom;

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - parametrised up/down BCD counter with load, clear and wrap/saturate
//
// Purpose: DIGITS-digit packed BCD counter (digit 0 in bits [3:0]) with
//          synchronous clear, validated parallel load, up/down counting,
//          terminal-count flags and registered ovf/unf/load_err pulses.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous reset, active-low
//   clear     in   synchronous clear to zero
//   load      in   parallel load strobe
//   load_val  in   packed BCD value to load
//   up        in   count-up enable
//   down      in   count-down enable
//   bcd       out  registered counter value
//   is_zero   out  all digits zero
//   is_max    out  all digits nine
//   ovf       out  pulse: up-count attempted at all-9s
//   unf       out  pulse: down-count attempted at zero
//   load_err  out  pulse: load rejected for a digit >9

module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [DIGITS*4-1:0] load_val,
  input  logic                up,
  input  logic                down,
  output logic [DIGITS*4-1:0] bcd,
  output logic                is_zero,
  output logic                is_max,
  output logic                ovf,
  output logic                unf,
  output logic                load_err
);

  logic [DIGITS-1:0] inc_out_w;
  logic [DIGITS-1:0] dec_out_w;
  logic [DIGITS-1:0] nine_or_bad;
  logic [DIGITS-1:0] exact_nine;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] ld_digit_ok;

  logic load_ok;
  logic count_en;
  logic inc;
  logic dec;
  logic at_max_c;
  logic at_zero;
  logic inc_chain0;
  logic dec_chain0;
  logic do_load;

  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic load_err_q, load_err_d;

  // Counting only happens on cycles with neither clear nor load (even a
  // rejected load swallows the count). up and down together cancel.
  assign count_en = ~clear & ~load;
  assign inc      = count_en & up & ~down;
  assign dec      = count_en & down & ~up;

  assign load_ok  = &ld_digit_ok;
  assign do_load  = load & load_ok;

  // Terminal detection matches the carry rule, so a corrupted digit counts as 9.
  assign at_max_c = &nine_or_bad;
  assign at_zero  = &digit_zero;

  // In saturate mode the chain never sees the terminal step, so bcd holds.
  assign inc_chain0 = inc & ~(SATURATE & at_max_c);
  assign dec_chain0 = dec & ~(SATURATE & at_zero);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_t dig;

    bcd_updown_digit u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_in  ((i == 0) ? inc_chain0 : inc_out_w[(i == 0) ? 0 : i-1]),
      .dec_in  ((i == 0) ? dec_chain0 : dec_out_w[(i == 0) ? 0 : i-1]),
      .clr     (clear),
      .ld      (do_load),
      .ld_val  (load_val[4*i +: 4]),
      .digit   (dig),
      .inc_out (inc_out_w[i]),
      .dec_out (dec_out_w[i])
    );

    assign bcd[4*i +: 4] = dig;
    assign nine_or_bad[i] = (dig == BCD_MAX) || !bcd_valid(dig);
    assign exact_nine[i]  = (dig == BCD_MAX);
    assign digit_zero[i]  = (dig == BCD_ZERO);
    assign ld_digit_ok[i] = bcd_valid(load_val[4*i +: 4]);
  end

  // In wrap mode the carry falling off the top digit is the overflow; in
  // saturate mode the chain is gated, so the terminal term supplies it.
  always_comb begin
    ovf_d      = inc_out_w[DIGITS-1] | (SATURATE & inc & at_max_c);
    unf_d      = dec_out_w[DIGITS-1] | (SATURATE & dec & at_zero);
    load_err_d = ~clear & load & ~load_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      load_err_q <= load_err_d;
    end
  end

  assign is_zero  = at_zero;
  assign is_max   = &exact_nine;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter (wrap and saturate)

module tb_bcd_updown_counter;

  localparam int D    = 3;
  localparam int W    = D * 4;
  localparam int MAXV = 999;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         up;
  logic         down;

  logic [W-1:0] bcd0, bcd1;
  logic         z0, z1, m0, m1, o0, o1, u0, u1, e0, e1;

  int tests = 0;
  int fails = 0;

  // Reference state as plain integers, index 0 = wrap, 1 = saturate.
  int mv[2];
  bit mo[2];
  bit mu[2];
  bit me[2];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(D), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .up(up), .down(down), .bcd(bcd0), .is_zero(z0), .is_max(m0),
    .ovf(o0), .unf(u0), .load_err(e0)
  );

  bcd_updown_counter #(.DIGITS(D), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .up(up), .down(down), .bcd(bcd1), .is_zero(z1), .is_max(m1),
    .ovf(o1), .unf(u1), .load_err(e1)
  );

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(logic [W-1:0] b);
    for (int i = 0; i < D; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int bcd_to_int(logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter as an integer 0..999 updated by the rules.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      mo[s] = 1'b0;
      mu[s] = 1'b0;
      me[s] = 1'b0;
      if (!rst_n || clear) begin
        mv[s] = 0;
      end else if (load) begin
        if (bcd_ok(load_val)) mv[s] = bcd_to_int(load_val);
        else me[s] = 1'b1;
      end else if (up && !down) begin
        if (mv[s] == MAXV) begin
          mo[s] = 1'b1;
          mv[s] = (s == 1) ? MAXV : 0;
        end else begin
          mv[s] = mv[s] + 1;
        end
      end else if (down && !up) begin
        if (mv[s] == 0) begin
          mu[s] = 1'b1;
          mv[s] = (s == 1) ? 0 : MAXV;
        end else begin
          mv[s] = mv[s] - 1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("wrap.bcd",      32'(bcd0), 32'(to_bcd(mv[0])));
    chk("wrap.is_zero",  32'(z0),   32'(mv[0] == 0));
    chk("wrap.is_max",   32'(m0),   32'(mv[0] == MAXV));
    chk("wrap.ovf",      32'(o0),   32'(mo[0]));
    chk("wrap.unf",      32'(u0),   32'(mu[0]));
    chk("wrap.load_err", 32'(e0),   32'(me[0]));
    chk("sat.bcd",       32'(bcd1), 32'(to_bcd(mv[1])));
    chk("sat.is_zero",   32'(z1),   32'(mv[1] == 0));
    chk("sat.is_max",    32'(m1),   32'(mv[1] == MAXV));
    chk("sat.ovf",       32'(o1),   32'(mo[1]));
    chk("sat.unf",       32'(u1),   32'(mu[1]));
    chk("sat.load_err",  32'(e1),   32'(me[1]));
  end

  task automatic drive(input bit r, input bit c, input bit l, input logic [W-1:0] lv,
                       input bit uu, input bit dd);
    rst_n    = r;
    clear    = c;
    load     = l;
    load_val = lv;
    up       = uu;
    down     = dd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; up = 1'b0; down = 1'b0;

    // Reset state.
    drive(0, 0, 0, 12'h000, 0, 0);
    drive(0, 0, 0, 12'h000, 1, 0);
    chk("pin.rst.bcd",  32'(bcd0), 32'h000);
    chk("pin.rst.zero", 32'(z0),   32'd1);
    chk("pin.rst.max",  32'(m0),   32'd0);
    chk("pin.rst.ovf",  32'(o0),   32'd0);

    // Wrap: 998 then up x3.
    drive(1, 0, 1, 12'h998, 0, 0);
    chk("pin.ld998", 32'(bcd0), 32'h998);
    drive(1, 0, 0, 12'h000, 1, 0);
    chk("pin.up1.bcd", 32'(bcd0), 32'h999);
    chk("pin.up1.ovf", 32'(o0),   32'd0);
    chk("pin.up1.max", 32'(m0),   32'd1);
    drive(1, 0, 0, 12'h000, 1, 0);
    chk("pin.up2.bcd", 32'(bcd0), 32'h000);
    chk("pin.up2.ovf", 32'(o0),   32'd1);
    chk("pin.up2.sat", 32'(bcd1), 32'h999);
    chk("pin.up2.sovf", 32'(o1),  32'd1);
    drive(1, 0, 0, 12'h000, 1, 0);
    chk("pin.up3.bcd", 32'(bcd0), 32'h001);
    chk("pin.up3.ovf", 32'(o0),   32'd0);

    // Saturate: 001 then down x3.
    drive(1, 0, 1, 12'h001, 0, 0);
    drive(1, 0, 0, 12'h000, 0, 1);
    chk("pin.dn1.sbcd", 32'(bcd1), 32'h000);
    chk("pin.dn1.sunf", 32'(u1),   32'd0);
    chk("pin.dn1.szero", 32'(z1),  32'd1);
    drive(1, 0, 0, 12'h000, 0, 1);
    chk("pin.dn2.sbcd", 32'(bcd1), 32'h000);
    chk("pin.dn2.sunf", 32'(u1),   32'd1);
    chk("pin.dn2.wbcd", 32'(bcd0), 32'h999);
    chk("pin.dn2.wunf", 32'(u0),   32'd1);
    drive(1, 0, 0, 12'h000, 0, 1);
    chk("pin.dn3.sbcd", 32'(bcd1), 32'h000);
    chk("pin.dn3.sunf", 32'(u1),   32'd1);
    chk("pin.dn3.szero", 32'(z1),  32'd1);
    chk("pin.dn3.wbcd", 32'(bcd0), 32'h998);

    // Borrow across two digits.
    drive(1, 0, 1, 12'h100, 0, 0);
    drive(1, 0, 0, 12'h000, 0, 1);
    chk("pin.borrow.bcd", 32'(bcd0), 32'h099);
    chk("pin.borrow.unf", 32'(u0),   32'd0);

    // Rejected load, then load with up ignored.
    drive(1, 0, 1, 12'h1A3, 0, 0);
    chk("pin.badld.err", 32'(e0),   32'd1);
    chk("pin.badld.bcd", 32'(bcd0), 32'h099);
    drive(1, 0, 1, 12'h123, 1, 0);
    chk("pin.ldup.bcd", 32'(bcd0), 32'h123);
    chk("pin.ldup.err", 32'(e0),   32'd0);

    // up=down hold, then clear beats load.
    drive(1, 0, 1, 12'h050, 0, 0);
    drive(1, 0, 0, 12'h000, 1, 1);
    drive(1, 0, 0, 12'h000, 1, 1);
    chk("pin.hold.bcd", 32'(bcd0), 32'h050);
    chk("pin.hold.pulses", 32'({o0, u0, e0}), 32'd0);
    drive(1, 1, 1, 12'h999, 0, 0);
    chk("pin.clr.bcd", 32'(bcd0), 32'h000);

    // Reset mid-count.
    drive(1, 0, 1, 12'h457, 0, 0);
    drive(0, 0, 0, 12'h000, 1, 0);
    chk("pin.midrst.bcd",  32'(bcd0), 32'h000);
    chk("pin.midrst.ovf",  32'(o0),   32'd0);
    chk("pin.midrst.zero", 32'(z0),   32'd1);
    drive(1, 0, 0, 12'h000, 1, 0);
    chk("pin.resume.bcd", 32'(bcd0), 32'h001);

    // Randomised phase, biased toward the terminal values.
    for (int n = 0; n < 3000; n++) begin
      bit r, c, l, uu, dd;
      logic [W-1:0] lv;
      int pick;
      r    = ($urandom_range(0, 99) != 0);
      c    = ($urandom_range(0, 39) == 0);
      l    = ($urandom_range(0, 7) == 0);
      pick = $urandom_range(0, 5);
      case (pick)
        0: lv = to_bcd(0);
        1: lv = to_bcd(MAXV);
        2: lv = to_bcd(1);
        3: lv = to_bcd(MAXV - 1);
        4: lv = to_bcd($urandom_range(0, MAXV));
        default: lv = W'($urandom);
      endcase
      uu = ($urandom_range(0, 2) != 0) ? n[8] : ~n[8];
      dd = ($urandom_range(0, 2) != 0) ? ~n[8] : n[8];
      if ($urandom_range(0, 9) == 0) begin
        uu = 1'b1;
        dd = 1'b1;
      end
      drive(r, c, l, lv, uu, dd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
